// File: rtl/txt_writer.sv
// ---------------------------------------------------------------------------
// txt_writer
//   Character-stream front end for text mode. Accepts one host byte per
//   valid/ready handshake, writes printable characters into character RAM
//   at the cursor, handles CR / LF / backspace, and clears every newly
//   entered line. Character RAM is addressed as line*128 + column.
//
// Parameters:
//   COLS        visible columns per line (at most 128)
//   CLEAR_CHAR  byte written into every column of a cleared line
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous, active-high reset
//   in_valid  in   host byte valid
//   in_char   in   host byte
//   in_ready  out  block can accept a byte this cycle
//   wr_en     out  character RAM write strobe
//   wr_addr   out  character RAM address {1'b0, line[7:0], col[6:0]}
//   wr_data   out  character RAM write data
//   y_reg     out  absolute cursor line, 0..255, wraps
//   cur_x     out  cursor column, 0..COLS-1
//   busy      out  high while writing a character or clearing a line
// ---------------------------------------------------------------------------
module txt_writer #(
    parameter int          COLS       = 80,
    parameter logic [7:0]  CLEAR_CHAR = 8'h20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_char,
    output logic        in_ready,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic [7:0]  y_reg,
    output logic [6:0]  cur_x,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CLEAR = 2'd2
    } state_t;

    localparam logic [6:0] LAST_COL = 7'(COLS - 1);

    state_t     state;
    logic [6:0] x;
    logic [7:0] y;
    logic [6:0] clr_cnt;
    logic [7:0] ch;

    // Printable ASCII range that lands in character RAM.
    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

    // Cursor / line-clear state machine. Reset enters CLEAR so that line 0
    // is blanked before the first host byte is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= 7'd0;
            x       <= 7'd0;
            y       <= 8'd0;
            ch      <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    // in_ready is exactly (state == IDLE) here, so in_valid
                    // alone marks a transfer.
                    if (in_valid) begin
                        if (is_printable(in_char)) begin
                            ch    <= in_char;
                            state <= WRITE;
                        end else begin
                            case (in_char)
                                8'h0A: begin
                                    x       <= 7'd0;
                                    y       <= y + 8'd1;
                                    clr_cnt <= 7'd0;
                                    state   <= CLEAR;
                                end
                                8'h0D: begin
                                    x <= 7'd0;
                                end
                                8'h08: begin
                                    if (x != 7'd0) begin
                                        x <= x - 7'd1;
                                    end else begin
                                        x <= x;
                                    end
                                end
                                default: begin
                                    // Unsupported control byte: consumed, no effect.
                                    state <= IDLE;
                                end
                            endcase
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                WRITE: begin
                    // Writing the last column wraps onto a fresh, cleared line.
                    if (x == LAST_COL) begin
                        x       <= 7'd0;
                        y       <= y + 8'd1;
                        clr_cnt <= 7'd0;
                        state   <= CLEAR;
                    end else begin
                        x     <= x + 7'd1;
                        state <= IDLE;
                    end
                end
                CLEAR: begin
                    clr_cnt <= clr_cnt + 7'd1;
                    if (clr_cnt == LAST_COL) begin
                        state <= IDLE;
                    end else begin
                        state <= CLEAR;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output decode from state registers; rst forces the RAM port quiet so
    // an aborted clear cannot write during reset.
    always_comb begin
        in_ready = (state == IDLE) && !rst;
        busy     = (state == WRITE) || (state == CLEAR);
        cur_x    = x;
        y_reg    = y;
        wr_en    = 1'b0;
        wr_addr  = 16'd0;
        wr_data  = 8'd0;
        if (!rst) begin
            case (state)
                WRITE: begin
                    wr_en   = 1'b1;
                    wr_addr = {1'b0, y, x};
                    wr_data = ch;
                end
                CLEAR: begin
                    wr_en   = 1'b1;
                    wr_addr = {1'b0, y, clr_cnt};
                    wr_data = CLEAR_CHAR;
                end
                default: begin
                    wr_en   = 1'b0;
                    wr_addr = 16'd0;
                    wr_data = 8'd0;
                end
            endcase
        end else begin
            wr_en   = 1'b0;
            wr_addr = 16'd0;
            wr_data = 8'd0;
        end
    end

endmodule

// File: tb/tb_txt_writer.sv
// ---------------------------------------------------------------------------
// tb_txt_writer
//   Directed self-checking bench for txt_writer. Inputs change 1 time unit
//   after a rising edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_txt_writer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_char;
    logic        in_ready;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic [7:0]  y_reg;
    logic [6:0]  cur_x;
    logic        busy;

    int errors = 0;
    int checks = 0;

    txt_writer #(.COLS(80), .CLEAR_CHAR(8'h20)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_char  (in_char),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .y_reg    (y_reg),
        .cur_x    (cur_x),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Present one byte for a single accept cycle (caller ensures IDLE).
    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_char  = b;
        next_cycle();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!in_ready && n < budget) begin
            next_cycle();
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL wait_idle: in_ready=%b expected 1 within %0d cycles", in_ready, budget);
        end
    endtask

    task automatic send_lf_drain();
        send_byte(8'h0A);
        wait_idle(100);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_char = 8'h00;
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++;
        if ({wr_en, wr_addr, wr_data, in_ready} !== {1'b0, 16'h0000, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: en=%b addr=%h data=%h rdy=%b expected 0/0000/00/0",
                     wr_en, wr_addr, wr_data, in_ready);
        end
        checks++;
        if ({y_reg, cur_x} !== {8'd0, 7'd0}) begin
            errors++;
            $display("FAIL reset_cursor: y=%0d x=%0d expected 0/0", y_reg, cur_x);
        end
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            checks++;
            if ({wr_en, wr_addr, wr_data, in_ready} !== {1'b1, 16'(i), 8'h20, 1'b0}) begin
                errors++;
                $display("FAIL init_clear[%0d]: en=%b addr=%h data=%h rdy=%b expected 1/%h/20/0",
                         i, wr_en, wr_addr, wr_data, in_ready, 16'(i));
            end
            next_cycle();
        end
        @(negedge clk);
        checks++;
        if ({in_ready, wr_en} !== 2'b10) begin
            errors++;
            $display("FAIL init_done: rdy=%b en=%b expected 1/0", in_ready, wr_en);
        end
        next_cycle();
    endtask

    task automatic test_single_char();
        send_byte(8'h41);
        @(negedge clk);
        checks++;
        if ({wr_en, wr_addr, wr_data, in_ready} !== {1'b1, 16'h0000, 8'h41, 1'b0}) begin
            errors++;
            $display("FAIL single_write: en=%b addr=%h data=%h rdy=%b expected 1/0000/41/0",
                     wr_en, wr_addr, wr_data, in_ready);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({in_ready, wr_en, cur_x} !== {1'b1, 1'b0, 7'd1}) begin
            errors++;
            $display("FAIL single_after: rdy=%b en=%b x=%0d expected 1/0/1", in_ready, wr_en, cur_x);
        end
        next_cycle();
    endtask

    task automatic test_line_fill();
        send_byte(8'h0D);
        for (int k = 0; k < 80; k++) begin
            send_byte(8'h30);
            @(negedge clk);
            checks++;
            if ({wr_en, wr_addr, wr_data} !== {1'b1, 16'(k), 8'h30}) begin
                errors++;
                $display("FAIL fill_write[%0d]: en=%b addr=%h data=%h expected 1/%h/30",
                         k, wr_en, wr_addr, wr_data, 16'(k));
            end
            next_cycle();
        end
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            checks++;
            if ({wr_en, wr_addr, wr_data, y_reg, cur_x} !==
                {1'b1, 16'(128 + i), 8'h20, 8'd1, 7'd0}) begin
                errors++;
                $display("FAIL wrap_clear[%0d]: en=%b addr=%h data=%h y=%0d x=%0d expected 1/%h/20/1/0",
                         i, wr_en, wr_addr, wr_data, y_reg, cur_x, 16'(128 + i));
            end
            next_cycle();
        end
        wait_idle(4);
        send_byte(8'h31);
        @(negedge clk);
        checks++;
        if ({wr_en, wr_addr, wr_data} !== {1'b1, 16'h0080, 8'h31}) begin
            errors++;
            $display("FAIL wrap_next: en=%b addr=%h data=%h expected 1/0080/31", wr_en, wr_addr, wr_data);
        end
        next_cycle();
    endtask

    task automatic test_lf_cr_bs();
        for (int i = 0; i < 28; i++) send_lf_drain();
        send_byte(8'h0D);
        for (int i = 0; i < 5; i++) begin
            send_byte(8'h35);
            wait_idle(4);
        end
        checks++;
        if ({y_reg, cur_x} !== {8'd29, 7'd5}) begin
            errors++;
            $display("FAIL lf_setup: y=%0d x=%0d expected 29/5", y_reg, cur_x);
        end
        send_byte(8'h0A);
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            checks++;
            if ({wr_en, wr_addr, wr_data, y_reg, cur_x} !==
                {1'b1, 16'(16'h0F00 + i), 8'h20, 8'd30, 7'd0}) begin
                errors++;
                $display("FAIL lf_clear[%0d]: en=%b addr=%h data=%h y=%0d x=%0d expected 1/%h/20/30/0",
                         i, wr_en, wr_addr, wr_data, y_reg, cur_x, 16'(16'h0F00 + i));
            end
            next_cycle();
        end
        wait_idle(4);
        send_byte(8'h0D);
        @(negedge clk);
        checks++;
        if ({wr_en, in_ready, cur_x, y_reg} !== {1'b0, 1'b1, 7'd0, 8'd30}) begin
            errors++;
            $display("FAIL cr: en=%b rdy=%b x=%0d y=%0d expected 0/1/0/30", wr_en, in_ready, cur_x, y_reg);
        end
        next_cycle();
        send_byte(8'h08);
        @(negedge clk);
        checks++;
        if ({wr_en, in_ready, cur_x, y_reg} !== {1'b0, 1'b1, 7'd0, 8'd30}) begin
            errors++;
            $display("FAIL bs_at_zero: en=%b rdy=%b x=%0d y=%0d expected 0/1/0/30", wr_en, in_ready, cur_x, y_reg);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            send_byte(8'h43);
            wait_idle(4);
        end
        send_byte(8'h08);
        @(negedge clk);
        checks++;
        if ({wr_en, cur_x} !== {1'b0, 7'd2}) begin
            errors++;
            $display("FAIL bs: en=%b x=%0d expected 0/2", wr_en, cur_x);
        end
        next_cycle();
        send_byte(8'h07);
        @(negedge clk);
        checks++;
        if ({wr_en, in_ready, cur_x, y_reg} !== {1'b0, 1'b1, 7'd2, 8'd30}) begin
            errors++;
            $display("FAIL ignored_byte: en=%b rdy=%b x=%0d y=%0d expected 0/1/2/30", wr_en, in_ready, cur_x, y_reg);
        end
        next_cycle();
        // in_valid held across three cycles: accept, write, accept.
        in_valid = 1'b1;
        in_char  = 8'h42;
        @(negedge clk);
        checks++;
        if ({in_ready, wr_en} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_accept1: rdy=%b en=%b expected 1/0", in_ready, wr_en);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({wr_en, wr_addr, wr_data, in_ready} !== {1'b1, 16'h0F02, 8'h42, 1'b0}) begin
            errors++;
            $display("FAIL b2b_write1: en=%b addr=%h data=%h rdy=%b expected 1/0f02/42/0", wr_en, wr_addr, wr_data, in_ready);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({in_ready, wr_en} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_accept2: rdy=%b en=%b expected 1/0", in_ready, wr_en);
        end
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({wr_en, wr_addr, wr_data} !== {1'b1, 16'h0F03, 8'h42}) begin
            errors++;
            $display("FAIL b2b_write2: en=%b addr=%h data=%h expected 1/0f03/42", wr_en, wr_addr, wr_data);
        end
        next_cycle();
        checks++;
        if ({in_ready, cur_x} !== {1'b1, 7'd4}) begin
            errors++;
            $display("FAIL b2b_end: rdy=%b x=%0d expected 1/4", in_ready, cur_x);
        end
    endtask

    task automatic test_wrap_and_reset();
        for (int i = 0; i < 225; i++) send_lf_drain();
        checks++;
        if (y_reg !== 8'd255) begin
            errors++;
            $display("FAIL wrap_setup: y=%0d expected 255", y_reg);
        end
        send_byte(8'h0A);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            checks++;
            if ({wr_en, wr_addr, wr_data, y_reg} !== {1'b1, 16'(i), 8'h20, 8'd0}) begin
                errors++;
                $display("FAIL y_wrap_clear[%0d]: en=%b addr=%h data=%h y=%0d expected 1/%h/20/0",
                         i, wr_en, wr_addr, wr_data, y_reg, 16'(i));
            end
            next_cycle();
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({wr_en, wr_addr, wr_data, in_ready} !== {1'b0, 16'h0000, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL abort: en=%b addr=%h data=%h rdy=%b expected 0/0000/00/0", wr_en, wr_addr, wr_data, in_ready);
        end
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            checks++;
            if ({wr_en, wr_addr, wr_data, in_ready} !== {1'b1, 16'(i), 8'h20, 1'b0}) begin
                errors++;
                $display("FAIL restart_clear[%0d]: en=%b addr=%h data=%h rdy=%b expected 1/%h/20/0",
                         i, wr_en, wr_addr, wr_data, in_ready, 16'(i));
            end
            next_cycle();
        end
        checks++;
        if ({in_ready, wr_en, cur_x, y_reg} !== {1'b1, 1'b0, 7'd0, 8'd0}) begin
            errors++;
            $display("FAIL restart_done: rdy=%b en=%b x=%0d y=%0d expected 1/0/0/0", in_ready, wr_en, cur_x, y_reg);
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_char  = 8'h00;
        next_cycle();
        test_reset();
        test_single_char();
        test_line_fill();
        test_lf_cr_bs();
        test_back_to_back();
        test_wrap_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
